mem_access_unit: RTL

- MEM-stage block, directly downstream of decode/execute. Consumes the mem_read / mem_write / wb_enable controls produced in decode and carried through EX/MEM.
- Sequences data-memory accesses over a variable-latency req/ready interface: LDR is one read, STR is one write, SWP is an atomic read then write.
- Asserts freeze to hold the upstream pipeline until the access completes, then registers the result into MEM/WB.

---
 rtl/mem_access_unit_pkg.sv | 38 +++
 rtl/mem_access_unit_mem_wb_reg.sv | 77 +++++++
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared state encoding and helpers for the MEM-stage access unit
package mem_access_unit_pkg;

    localparam int MEM_BASE_DEFAULT = 1024;
    localparam int STATE_W          = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_WR     = 3'd2,
        S_SWP_RD = 3'd3,
        S_SWP_WR = 3'd4,
        S_DONE   = 3'd5
    } mau_state_e;

    // A swap is encoded by decode as both mem_read and mem_write asserted.
    function automatic logic is_swp(input logic rd, input logic wr);
        return rd & wr;
    endfunction

    function automatic mau_state_e first_state(input logic rd, input logic wr);
        if (is_swp(rd, wr)) begin
            return S_SWP_RD;
        end else if (wr) begin
            return S_WR;
        end
        return S_RD;
    endfunction

    function automatic logic is_access_state(input mau_state_e s);
        return (s == S_RD) || (s == S_WR) || (s == S_SWP_RD) || (s == S_SWP_WR);
    endfunction

    function automatic logic is_write_state(input mau_state_e s);
        return (s == S_WR) || (s == S_SWP_WR);
    endfunction

endpackage

// File: rtl/mem_access_unit_mem_wb_reg.sv
// rtl/mem_access_unit_mem_wb_reg.sv - MEM/WB pipeline register with load and bubble insert
module mem_wb_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bubble,
    input  logic              valid_in,
    input  logic              wb_enable_in,
    input  logic              mem_read_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic [3:0]        dest_in,
    output logic              valid_out,
    output logic              wb_enable_out,
    output logic              mem_read_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [3:0]        dest_out
);

    logic              valid_q, valid_d;
    logic              wb_enable_q, wb_enable_d;
    logic              mem_read_q, mem_read_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [3:0]        dest_q, dest_d;

    // Bubble clears only the control bits; data fields are don't-care once valid is low.
    always_comb begin
        valid_d      = valid_q;
        wb_enable_d  = wb_enable_q;
        mem_read_d   = mem_read_q;
        alu_result_d = alu_result_q;
        mem_data_d   = mem_data_q;
        dest_d       = dest_q;
        if (bubble) begin
            valid_d     = 1'b0;
            wb_enable_d = 1'b0;
            mem_read_d  = 1'b0;
        end else if (load) begin
            valid_d      = valid_in;
            wb_enable_d  = wb_enable_in;
            mem_read_d   = mem_read_in;
            alu_result_d = alu_result_in;
            mem_data_d   = mem_data_in;
            dest_d       = dest_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            wb_enable_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            alu_result_q <= '0;
            mem_data_q   <= '0;
            dest_q       <= '0;
        end else begin
            valid_q      <= valid_d;
            wb_enable_q  <= wb_enable_d;
            mem_read_q   <= mem_read_d;
            alu_result_q <= alu_result_d;
            mem_data_q   <= mem_data_d;
            dest_q       <= dest_d;
        end
    end

    assign valid_out      = valid_q;
    assign wb_enable_out  = wb_enable_q;
    assign mem_read_out   = mem_read_q;
    assign alu_result_out = alu_result_q;
    assign mem_data_out   = mem_data_q;
    assign dest_out       = dest_q;

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage: sequences LDR/STR/SWP over a req/ready memory port
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int MEM_BASE = MEM_BASE_DEFAULT,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              wb_enable,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [3:0]        dest,
    output logic              freeze,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              valid_out,
    output logic              wb_enable_out,
    output logic              mem_read_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [3:0]        dest_out
);

    mau_state_e        state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;

    logic              mem_op;
    logic [DATA_W-1:0] rel_addr;
    logic              out_load;
    mau_state_e        entry_state;

    assign mem_op      = valid_in & (mem_read | mem_write);
    assign rel_addr    = alu_result - DATA_W'(MEM_BASE);
    assign entry_state = first_state(mem_read, mem_write);

    // Freeze covers the accepting IDLE cycle so EX/MEM holds the instruction until DONE.
    assign freeze   = ((state_q == S_IDLE) & mem_op) | is_access_state(state_q);
    assign out_load = ((state_q == S_IDLE) & ~mem_op) | (state_q == S_DONE);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        mem_req_d = mem_req_q;
        mem_we_d  = mem_we_q;
        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    addr_d    = {rel_addr[DATA_W-1:2], 2'b00};
                    wdata_d   = val_rm;
                    state_d   = entry_state;
                    mem_req_d = 1'b1;
                    mem_we_d  = is_write_state(entry_state);
                end
            end
            S_RD: begin
                if (mem_ready) begin
                    rdata_d   = mem_rdata;
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                end
            end
            S_WR: begin
                if (mem_ready) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            S_SWP_RD: begin
                // Old value becomes the write-back result; request stays up for the write half.
                if (mem_ready) begin
                    rdata_d  = mem_rdata;
                    state_d  = S_SWP_WR;
                    mem_we_d = 1'b1;
                end
            end
            S_SWP_WR: begin
                if (mem_ready) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    mem_wb_reg #(
        .DATA_W(DATA_W)
    ) u_mem_wb_reg (
        .clk            (clk),
        .rst            (rst),
        .load           (out_load),
        .bubble         (freeze),
        .valid_in       (valid_in),
        .wb_enable_in   (wb_enable),
        .mem_read_in    (mem_read),
        .alu_result_in  (alu_result),
        .mem_data_in    (rdata_q),
        .dest_in        (dest),
        .valid_out      (valid_out),
        .wb_enable_out  (wb_enable_out),
        .mem_read_out   (mem_read_out),
        .alu_result_out (alu_result_out),
        .mem_data_out   (mem_data_out),
        .dest_out       (dest_out)
    );

endmodule
